// File: rtl/lattice_sched_pkg.sv
// lattice_sched_pkg: shared definitions for the lattice backward-induction
// scheduler, the 4-bank address decoder and the pricing datapath.
package lattice_sched_pkg;

    // Node address width, shared with the bank decoder's addr_in
    localparam int DEF_ADDR_W   = 13;

    // Read-to-write-back latency of the pricing pipeline (legal 1..15)
    localparam int DEF_PIPE_LAT = 6;

    // Width of the DRAIN cycle counter, large enough for PIPE_LAT up to 15
    localparam int DRAIN_CNT_W  = 4;

    // Scheduler sweep states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

endpackage

// File: rtl/lattice_sched_if.sv
// lattice_sched_if: start/done handshake plus read/write node address bus
// between a sweep requester (master) and the scheduler (slave).
interface lattice_sched_if
    import lattice_sched_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              start;
    logic [ADDR_W-1:0] num_steps;
    logic              busy;
    logic              done;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] step;

    modport master (
        output start, num_steps,
        input  busy, done, rd_valid, rd_addr, wr_en, wr_addr, step
    );

    modport slave (
        input  start, num_steps,
        output busy, done, rd_valid, rd_addr, wr_en, wr_addr, step
    );
endinterface

// File: rtl/lattice_delay_line.sv
// lattice_delay_line: DEPTH-deep shift register of {valid, addr} with
// asynchronous clear; also used by the datapath for operand alignment.
module lattice_delay_line
    import lattice_sched_pkg::*;
#(
    parameter int DEPTH = DEF_PIPE_LAT,
    parameter int W     = DEF_ADDR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_addr,
    output logic         out_valid,
    output logic [W-1:0] out_addr
);
    logic [DEPTH-1:0] valid_sr;
    logic [W-1:0]     addr_sr [DEPTH];

    // Shift every stage by one each cycle; reset empties the whole line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_sr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_sr[i] <= '0;
            end
        end else begin
            valid_sr[0] <= in_valid;
            addr_sr[0]  <= in_addr;
            for (int i = 1; i < DEPTH; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                addr_sr[i]  <= addr_sr[i-1];
            end
        end
    end

    assign out_valid = valid_sr[DEPTH-1];
    assign out_addr  = addr_sr[DEPTH-1];
endmodule

// File: rtl/lattice_sched.sv
// lattice_sched: backward-induction sweep scheduler. Walks time steps N-1..0,
// reading nodes 0..step each step, then idles PIPE_LAT cycles so the
// write-backs land before the next step re-reads them.
// Optional build macro LATTICE_SCHED_HOLD_EN adds a 'hold' input that
// pauses reads and the drain counter while in-flight writes complete.
module lattice_sched
    import lattice_sched_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic           clk,
    input  logic           rst,
`ifdef LATTICE_SCHED_HOLD_EN
    input  logic           hold,
`endif
    lattice_sched_if.slave bus
);
    sched_state_e           state_q, state_d;
    logic [ADDR_W-1:0]      node_q, node_d;
    logic [ADDR_W-1:0]      step_q, step_d;
    logic [DRAIN_CNT_W-1:0] drain_q, drain_d;
    logic                   done_q, done_d;
    logic                   rd_valid;
    logic                   hold_act;
    logic                   wr_en_w;
    logic [ADDR_W-1:0]      wr_addr_w;

`ifdef LATTICE_SCHED_HOLD_EN
    assign hold_act = hold;
`else
    assign hold_act = 1'b0;
`endif

    // Sweep state register; reset abandons any sweep with no done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            node_q  <= '0;
            step_q  <= '0;
            drain_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            node_q  <= node_d;
            step_q  <= step_d;
            drain_q <= drain_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: issue reads 0..step, drain PIPE_LAT cycles, step down
    always_comb begin
        state_d  = state_q;
        node_d   = node_q;
        step_d   = step_q;
        drain_d  = drain_q;
        done_d   = 1'b0;
        rd_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.num_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        step_d  = bus.num_steps - ADDR_W'(1);
                        node_d  = '0;
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (!hold_act) begin
                    rd_valid = 1'b1;
                    if (node_q == step_q) begin
                        drain_d = '0;
                        state_d = DRAIN;
                    end else begin
                        node_d = node_q + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (!hold_act) begin
                    if (drain_q == DRAIN_CNT_W'(PIPE_LAT - 1)) begin
                        node_d = '0;
                        if (step_q == '0) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            step_d  = step_q - ADDR_W'(1);
                            state_d = READ;
                        end
                    end else begin
                        drain_d = drain_q + DRAIN_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    lattice_delay_line #(
        .DEPTH (PIPE_LAT),
        .W     (ADDR_W)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_valid),
        .in_addr   (node_q),
        .out_valid (wr_en_w),
        .out_addr  (wr_addr_w)
    );

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.rd_valid = rd_valid;
    assign bus.rd_addr  = node_q;
    assign bus.step     = step_q;
    assign bus.wr_en    = wr_en_w;
    assign bus.wr_addr  = wr_addr_w;
endmodule

// File: tb/tb_lattice_sched.sv
// tb_lattice_sched: table-driven sweeps with a read/write-back scoreboard,
// plus hand-written reset-abort and hold sequences.
module tb_lattice_sched;
    localparam int AW  = 13;
    localparam int LAT = 6;

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic hold = 1'b0;

    always #5 clk = ~clk;

    lattice_sched_if #(.ADDR_W(AW)) bus ();

    lattice_sched #(
        .ADDR_W   (AW),
        .PIPE_LAT (LAT)
    ) dut (
        .clk  (clk),
        .rst  (rst),
`ifdef LATTICE_SCHED_HOLD_EN
        .hold (hold),
`endif
        .bus  (bus)
    );

    typedef struct {
        int addr;
        int stp;
    } rd_exp_t;

    typedef struct {
        int addr;
        int cyc;
    } wr_exp_t;

    typedef struct {
        int n;
        int exp_done;
        int exp_reads;
        int restart_at;
        int hold_at;
        int hold_len;
    } vec_t;

    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int t0 = 0;
    bit mon_en = 1'b0;
    int rd_count, wr_count, done_count, done_cyc, busy_seen;
    int rcount[64];
    int wcount[64];

    // Free-running cycle counter used to timestamp DUT events
    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc - t0);
        end
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearScoreboard();
        rd_q.delete();
        wr_q.delete();
        rd_count   = 0;
        wr_count   = 0;
        done_count = 0;
        done_cyc   = -1;
        busy_seen  = 0;
        for (int i = 0; i < 64; i++) begin
            rcount[i] = 0;
            wcount[i] = 0;
        end
    endtask

    // Monitor: compare reads with the expected order, schedule and match write-backs
    always @(negedge clk) begin
        int      a;
        rd_exp_t e;
        wr_exp_t w;
        if (mon_en) begin
            if (bus.busy) busy_seen = 1;
            if (bus.rd_valid) begin
                a = int'(bus.rd_addr);
                rd_count++;
                if (rd_q.size() == 0) begin
                    checkOutput("rd_unexpected", a, -1);
                end else begin
                    e = rd_q.pop_front();
                    checkOutput("rd_addr", a, e.addr);
                    checkOutput("rd_step", int'(bus.step), e.stp);
                end
                if (a < 64) begin
                    checkOutput("rd_after_writeback", wcount[a], rcount[a]);
                    rcount[a]++;
                end
                wr_q.push_back('{addr: a, cyc: cyc + LAT});
            end
            if (bus.wr_en) begin
                a = int'(bus.wr_addr);
                wr_count++;
                if (wr_q.size() == 0) begin
                    checkOutput("wr_unexpected", a, -1);
                end else begin
                    w = wr_q.pop_front();
                    checkOutput("wr_addr", a, w.addr);
                    checkOutput("wr_cycle", cyc - t0, w.cyc - t0);
                end
                if (a < 64) wcount[a]++;
            end
            if (bus.done) begin
                done_count++;
                done_cyc = cyc - t0;
                checkOutput("busy_at_done", int'(bus.busy), 0);
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        clearScoreboard();
        for (int t = v.n - 1; t >= 0; t--) begin
            for (int j = 0; j <= t; j++) begin
                rd_q.push_back('{addr: j, stp: t});
            end
        end
        mon_en = 1'b1;
        waitCycle();
        bus.start     = 1'b1;
        bus.num_steps = AW'(v.n);
        t0 = cyc;
        for (int k = 1; k <= 3000; k++) begin
            waitCycle();
            bus.start     = (k == v.restart_at);
            bus.num_steps = (k == v.restart_at) ? AW'(1) : AW'(k);
            hold = (v.hold_len > 0) && (k >= v.hold_at) && (k < v.hold_at + v.hold_len);
            if (done_count != 0) break;
        end
        bus.start = 1'b0;
        hold      = 1'b0;
        repeat (8) waitCycle();
        mon_en = 1'b0;
        checkOutput("done_count", done_count, 1);
        checkOutput("done_cycle", done_cyc, v.exp_done);
        checkOutput("read_count", rd_count, v.exp_reads);
        checkOutput("write_count", wr_count, v.exp_reads);
        checkOutput("reads_left", rd_q.size(), 0);
        checkOutput("writes_left", wr_q.size(), 0);
        checkOutput("busy_seen", busy_seen, (v.n != 0) ? 1 : 0);
    endtask

    vec_t vecs[6];

    initial begin
        int dcount;
        int wcnt;
        vec_t hv;

        vecs[0] = '{n: 0, exp_done: 1,  exp_reads: 0,  restart_at: 0, hold_at: 0, hold_len: 0};
        vecs[1] = '{n: 1, exp_done: 8,  exp_reads: 1,  restart_at: 0, hold_at: 0, hold_len: 0};
        vecs[2] = '{n: 2, exp_done: 16, exp_reads: 3,  restart_at: 0, hold_at: 0, hold_len: 0};
        vecs[3] = '{n: 3, exp_done: 25, exp_reads: 6,  restart_at: 0, hold_at: 0, hold_len: 0};
        vecs[4] = '{n: 5, exp_done: 46, exp_reads: 15, restart_at: 0, hold_at: 0, hold_len: 0};
        vecs[5] = '{n: 4, exp_done: 35, exp_reads: 10, restart_at: 5, hold_at: 0, hold_len: 0};

        bus.start     = 1'b0;
        bus.num_steps = '0;

        // Reset state
        #1 rst = 1'b1;
        #2;
        checkOutput("reset_busy", int'(bus.busy), 0);
        checkOutput("reset_done", int'(bus.done), 0);
        checkOutput("reset_rd_valid", int'(bus.rd_valid), 0);
        checkOutput("reset_wr_en", int'(bus.wr_en), 0);
        checkOutput("reset_step", int'(bus.step), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) waitCycle();

        for (int i = 0; i < 6; i++) begin
            $display("[TB] vector %0d: N=%0d restart_at=%0d", i, vecs[i].n, vecs[i].restart_at);
            applyStimulus(vecs[i]);
        end

        // Reset mid-READ of an N=5 sweep with reads still in the pipeline
        $display("[TB] reset abort during N=5 sweep");
        clearScoreboard();
        waitCycle();
        bus.start     = 1'b1;
        bus.num_steps = AW'(5);
        t0 = cyc;
        for (int k = 1; k <= 13; k++) begin
            waitCycle();
            bus.start = 1'b0;
        end
        checkOutput("pre_reset_busy", int'(bus.busy), 1);
        checkOutput("pre_reset_rd_valid", int'(bus.rd_valid), 1);
        checkOutput("pre_reset_step", int'(bus.step), 3);
        checkOutput("pre_reset_rd_addr", int'(bus.rd_addr), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_busy", int'(bus.busy), 0);
        checkOutput("abort_rd_valid", int'(bus.rd_valid), 0);
        checkOutput("abort_rd_addr", int'(bus.rd_addr), 0);
        checkOutput("abort_step", int'(bus.step), 0);
        checkOutput("abort_done", int'(bus.done), 0);
        repeat (2) waitCycle();
        rst = 1'b0;
        dcount = 0;
        wcnt   = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) dcount++;
            if (bus.wr_en) wcnt++;
        end
        checkOutput("abort_no_done", dcount, 0);
        checkOutput("abort_no_wr_en", wcnt, 0);
        waitCycle();
        applyStimulus(vecs[2]);

`ifdef LATTICE_SCHED_HOLD_EN
        // Hold for three cycles during the first READ of an N=2 sweep
        $display("[TB] hold during first READ of N=2");
        hv = '{n: 2, exp_done: 19, exp_reads: 3, restart_at: 0, hold_at: 2, hold_len: 3};
        applyStimulus(hv);
`else
        hv = vecs[1];
        hv.restart_at = 3;
        applyStimulus(hv);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/lattice_sched.md
Name: lattice_sched

Overview:
Backward-induction scheduler for the binomial-lattice option engine. It walks time steps from N-1 down to 0. At each step it issues one node read per cycle: node j, with the bank decoder fetching the j/j+1 pair. It then issues the matching in-place write-back of node j after the fixed pricing-pipeline latency. The block drives the 13-bit node address into the 4-bank address decoder and sequences the whole lattice sweep from a single start/done handshake.

Parameters:
ADDR_W, 13, node address width; must match the decoder's addr_in width.
PIPE_LAT, 6, cycles from rd_valid to the matching wr_en (decode + memory + arithmetic); legal range 1..15.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  asynchronous active-high reset.
start  in  1  one-cycle request to begin a sweep; ignored unless idle.
num_steps  in  ADDR_W  lattice depth N; latched on accepted start.
busy  out  1  high while a sweep is in progress.
done  out  1  one-cycle pulse at sweep completion.
rd_valid  out  1  read issue strobe.
rd_addr  out  ADDR_W  node index j to read (decoder fetches j and j+1).
wr_en  out  1  write-back strobe for node rd_addr delayed by PIPE_LAT.
wr_addr  out  ADDR_W  node index to overwrite.
step  out  ADDR_W  current time step t being processed.

Behaviour:
- Reset: all outputs 0; state IDLE; delay line cleared. Reset mid-sweep aborts immediately. No done pulse is produced and no further wr_en is issued.
- States: IDLE, READ, DRAIN.
- IDLE, start=1 in cycle 0:
  - Latch N.
  - If N==0: done=1 in cycle 1, no reads, stay IDLE.
  - Else: busy=1 from cycle 1, step=N-1, node=0, enter READ.
- READ:
  - Each cycle: rd_valid=1, rd_addr=node.
  - node increments until node==step. That is step+1 reads per step, addresses 0..step ascending.
  - After the read of node==step, go to DRAIN.
- DRAIN:
  - Exactly PIPE_LAT cycles, rd_valid=0.
  - This guarantees the write of node 1 lands before the next step re-reads node 1.
  - On exit: if step==0, set busy=0 and done=1 in the same cycle, then IDLE. Else step<=step-1, node<=0, READ.
- Write path: PIPE_LAT-deep shift register of {rd_valid, rd_addr}. wr_en/wr_addr equal rd_valid/rd_addr delayed exactly PIPE_LAT cycles.
- Timing: done asserts at cycle 1 + N(N+1)/2 + N*PIPE_LAT (no hold). The final wr_en lands in the done cycle minus 1.
- start while busy: ignored. num_steps changes while busy: no effect.
- Arithmetic: node and step are unsigned ADDR_W. step never decrements below 0, and node never exceeds step. The decoder's j+1 is always <= N, so it fits ADDR_W.

Optional Feature:
LATTICE_SCHED_HOLD_EN
- Defined: adds input port hold (1 bit). While hold=1 in READ, rd_valid=0 and node freezes. In DRAIN, the DRAIN counter freezes. The write delay line keeps shifting, so in-flight writes complete. Releasing hold resumes exactly where the sweep stopped.
- Undefined: no hold port; the sweep runs uninterrupted.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE/READ/DRAIN);
  - the ADDR_W default, shared with the address decoder;
  - the PIPE_LAT default, shared with the pricing datapath.
- One sub-module, lattice_delay_line: a parameterised PIPE_LAT-deep shift register of {valid, addr} with async clear. It is reused by the datapath for operand alignment.

Test Plan:
- N=0, start -> done=1 in cycle 1, busy never high, no rd_valid/wr_en.
- N=1, PIPE_LAT=6 -> single read addr 0 at cycle 1; wr_en addr 0 at cycle 7; done at cycle 8.
- N=3 -> rd_addr sequence 0,1,2 | 0,1 | 0 with 6-cycle gaps; step outputs 2,1,0; done at cycle 1+6+18=25.
- For every rd issued at cycle c, check wr_en at c+6 with equal addr. Check no read of node k+1 in step t-1 precedes the write of node k+1 in step t.
- Reset asserted mid-READ of N=5 -> outputs 0 asynchronously; no done. A following start with N=2 completes normally at cycle 1+3+12=16.
- start pulsed again while busy (N=4 running) -> ignored, original sweep timing unchanged.
- HOLD_EN: N=2, hold high 3 cycles during the first READ -> done delayed by exactly 3 cycles; wr_en count still 3.
